ref_row_fetcher: RTL and testbench

Upstream feeder for the subpixel interpolation top level. On `start` it reads one 15x15 reference window (8x8 block plus 7-pixel filter margin) from a word-addressed pixel memory, two 64-bit words per row. It assembles each 120-bit row, buffers rows in a small FIFO, and presents them on a valid/ready handshake. Its output drives the interpolator's `in_row`.

---
 rtl/ref_row_fetcher.sv | 195 +++++++++++++++++++
 tb/tb_ref_row_fetcher.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ref_row_fetcher.sv
// Fetches a 15x15 reference window as 120-bit rows (two 64-bit words per row) into a small FIFO.
// Optional stall counter built only when REF_FETCH_STALL_CNT_EN is defined; otherwise stall_cnt is 0.
module ref_row_fetcher #(
    parameter int PIXEL_W    = 8,
    parameter int ROW_PIXELS = 15,
    parameter int NUM_ROWS   = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W-1:0]             stride,
    output logic                          busy,
    output logic                          done,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [63:0]                   mem_rd_data,
    output logic [PIXEL_W*ROW_PIXELS-1:0] in_row,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic [15:0]                   stall_cnt
);

    localparam int ROW_W = PIXEL_W * ROW_PIXELS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(NUM_ROWS + 1);

    // state    | meaning
    // IDLE     | waiting for start
    // FETCH_LO | lo word of current row on the bus (or waiting for FIFO space)
    // FETCH_HI | hi word of current row on the bus
    // DRAIN    | all reads issued, waiting for FIFO to empty
    // DONE     | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, FETCH_LO, FETCH_HI, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   row_idx, row_idx_nx;
    logic [ADDR_W-1:0]  row_addr, row_addr_nx;
    logic [ADDR_W-1:0]  stride_q, stride_nx;
    logic [ADDR_W-1:0]  mem_addr_nx;
    logic               rd_en_nx, rd_hi, rd_hi_nx;
    logic               reserve;
    logic [CNT_W-1:0]   pending;
    logic [CNT_W-1:0]   fifo_count;
    logic               space_ok, push, pop;
    logic               lo_vld, hi_vld;
    logic [63:0]        lo_word;
    logic [ROW_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               unused_hi_byte;

    assign unused_hi_byte = ^mem_rd_data[63:ROW_W-64];

    // pending counts rows whose lo read is committed but not yet pushed, so the
    // FIFO can never overflow even though the read decision is made a cycle early
    assign space_ok  = (fifo_count + pending) < CNT_W'(FIFO_DEPTH);
    assign push      = hi_vld;
    assign pop       = row_valid && row_ready;
    assign row_valid = (fifo_count != '0);
    assign in_row    = row_valid ? fifo_mem[rd_ptr] : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_nx    = state;
        row_idx_nx  = row_idx;
        row_addr_nx = row_addr;
        stride_nx   = stride_q;
        mem_addr_nx = mem_addr;
        rd_en_nx    = 1'b0;
        rd_hi_nx    = 1'b0;
        reserve     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx    = FETCH_LO;
                    row_idx_nx  = '0;
                    row_addr_nx = base_addr;
                    stride_nx   = stride;
                    if (space_ok) begin
                        rd_en_nx    = 1'b1;
                        mem_addr_nx = base_addr;
                        reserve     = 1'b1;
                    end
                end
            end
            FETCH_LO: begin
                if (mem_rd_en) begin
                    state_nx    = FETCH_HI;
                    rd_en_nx    = 1'b1;
                    rd_hi_nx    = 1'b1;
                    mem_addr_nx = row_addr + ADDR_W'(1);
                end else if (space_ok) begin
                    rd_en_nx    = 1'b1;
                    mem_addr_nx = row_addr;
                    reserve     = 1'b1;
                end
            end
            FETCH_HI: begin
                row_idx_nx  = row_idx + IDX_W'(1);
                row_addr_nx = row_addr + stride_q;
                if (row_idx == IDX_W'(NUM_ROWS - 1)) begin
                    state_nx = DRAIN;
                end else begin
                    state_nx = FETCH_LO;
                    if (space_ok) begin
                        rd_en_nx    = 1'b1;
                        mem_addr_nx = row_addr + stride_q;
                        reserve     = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pending == '0 &&
                    (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            row_idx   <= '0;
            row_addr  <= '0;
            stride_q  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rd_hi     <= 1'b0;
            pending   <= '0;
            lo_vld    <= 1'b0;
            hi_vld    <= 1'b0;
            lo_word   <= '0;
        end else begin
            state     <= state_nx;
            row_idx   <= row_idx_nx;
            row_addr  <= row_addr_nx;
            stride_q  <= stride_nx;
            mem_rd_en <= rd_en_nx;
            mem_addr  <= mem_addr_nx;
            rd_hi     <= rd_hi_nx;
            lo_vld    <= mem_rd_en && !rd_hi;
            hi_vld    <= mem_rd_en && rd_hi;
            if (lo_vld)
                lo_word <= mem_rd_data;
            case ({reserve, push})
                2'b10:   pending <= pending + CNT_W'(1);
                2'b01:   pending <= pending - CNT_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {mem_rd_data[ROW_W-65:0], lo_word};
    end

`ifdef REF_FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (state == IDLE && start)
            stall_cnt <= '0;
        else if (row_valid && !row_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ref_row_fetcher.sv
// Directed bench for ref_row_fetcher: word-equals-address memory, row content/order/timing checks.
module tb_ref_row_fetcher;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  base_addr;
    logic [15:0]  stride;
    logic         busy;
    logic         done;
    logic         mem_rd_en;
    logic [15:0]  mem_addr;
    logic [63:0]  mem_rd_data = '0;
    logic [119:0] in_row;
    logic         row_valid;
    logic         row_ready;
    logic [15:0]  stall_cnt;

    ref_row_fetcher dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .stride     (stride),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .in_row     (in_row),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (mem_rd_en)
            mem_rd_data <= 64'(mem_addr);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic         mon_en = 1'b0;
    int           rx_idx, first_vld, done_cyc, done_seen, rd_cnt, c0;
    logic [15:0]  exp_base, exp_stride;
    logic [119:0] got_rows [16];

    function automatic logic [119:0] exp_row(input int r);
        logic [15:0] lo, hi;
        lo = exp_base + exp_stride * 16'(r);
        hi = lo + 16'd1;
        return {56'(hi), 64'(lo)};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (row_valid && first_vld < 0)
                first_vld = cyc - c0;
            if (row_valid && row_ready) begin
                check_eq($sformatf("row%0d", rx_idx), 128'(in_row), 128'(exp_row(rx_idx)));
                if (rx_idx < 16)
                    got_rows[rx_idx] = in_row;
                rx_idx++;
            end
            if (done) begin
                done_cyc = cyc - c0;
                done_seen++;
            end
            if (mem_rd_en)
                rd_cnt++;
        end
    end

    // mode 0: ready high; 1: ready low until cycle 30; 2: low until 20 then toggle;
    // 3: ready high with extra start pulses while busy; 4: reset in cycles 10..12
    task automatic run_window(input logic [15:0] b, input logic [15:0] s, input int mode);
        exp_base   = b;
        exp_stride = s;
        rx_idx     = 0;
        first_vld  = -1;
        done_cyc   = -1;
        done_seen  = 0;
        rd_cnt     = 0;
        @(posedge clk); #1;
        c0        = cyc;
        start     = 1'b1;
        base_addr = b;
        stride    = s;
        row_ready = (mode == 0 || mode == 3 || mode == 4);
        mon_en    = 1'b1;
        for (int k = 1; k < 400; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mode == 0 && k == 1) begin
                check_eq("lo_rd_en", 128'(mem_rd_en), 128'(1));
                check_eq("lo_addr", 128'(mem_addr), 128'(b));
                check_eq("busy_c1", 128'(busy), 128'(1));
            end
            if (mode == 0 && k == 2)
                check_eq("hi_addr", 128'(mem_addr), 128'(b + 16'd1));
            case (mode)
                1: if (k == 30) begin
                    check_eq("hold_rd_en", 128'(mem_rd_en), 128'(0));
                    check_eq("hold_reads", 128'(rd_cnt), 128'(8));
                    check_eq("hold_no_pop", 128'(rx_idx), 128'(0));
                    check_eq("hold_valid", 128'(row_valid), 128'(1));
                    row_ready = 1'b1;
                end
                2: row_ready = (k >= 20) && (k % 2 == 0);
                3: if (k == 5 || k == 20) begin
                    start     = 1'b1;
                    base_addr = 16'h0500;
                    stride    = 16'h0001;
                end
                4: begin
                    if (k == 10)
                        rst = 1'b0;
                    else if (k == 11) begin
                        check_eq("rst_busy", 128'(busy), 128'(0));
                        check_eq("rst_done", 128'(done), 128'(0));
                        check_eq("rst_rd_en", 128'(mem_rd_en), 128'(0));
                        check_eq("rst_addr", 128'(mem_addr), 128'(0));
                        check_eq("rst_valid", 128'(row_valid), 128'(0));
                        check_eq("rst_in_row", 128'(in_row), 128'(0));
                        check_eq("rst_stall", 128'(stall_cnt), 128'(0));
                    end else if (k == 12) begin
                        rst    = 1'b1;
                        mon_en = 1'b0;
                        return;
                    end
                end
                default: ;
            endcase
            if (done_cyc >= 0)
                break;
        end
        check_eq("done_in_budget", 128'(done_cyc >= 0), 128'(1));
        repeat (4) @(posedge clk);
        #1;
        check_eq("row_count", 128'(rx_idx), 128'(15));
        check_eq("done_pulses", 128'(done_seen), 128'(1));
        check_eq("idle_after", 128'(busy), 128'(0));
        if (mode == 0 || mode == 3) begin
            check_eq("first_valid_cyc", 128'(first_vld), 128'(4));
            check_eq("done_cyc", 128'(done_cyc), 128'(33));
        end
        if (mode == 1) begin
`ifdef REF_FETCH_STALL_CNT_EN
            check_eq("stall_cnt", 128'(stall_cnt), 128'(26));
`else
            check_eq("stall_cnt", 128'(stall_cnt), 128'(0));
`endif
        end
        mon_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        row_ready = 1'b0;
        base_addr = '0;
        stride    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", 128'(busy), 128'(0));
        check_eq("reset_done", 128'(done), 128'(0));
        check_eq("reset_rd_en", 128'(mem_rd_en), 128'(0));
        check_eq("reset_addr", 128'(mem_addr), 128'(0));
        check_eq("reset_valid", 128'(row_valid), 128'(0));
        check_eq("reset_in_row", 128'(in_row), 128'(0));
        check_eq("reset_stall", 128'(stall_cnt), 128'(0));
        rst = 1'b1;
        repeat (2) @(posedge clk);

        run_window(16'h0100, 16'h0010, 0);
        check_eq("row0_direct", 128'(got_rows[0]), {8'h0, 56'h0101, 64'h0100});
        check_eq("row14_direct", 128'(got_rows[14]), {8'h0, 56'h01E1, 64'h01E0});
        check_eq("stall_nostall", 128'(stall_cnt), 128'(0));

        run_window(16'h0100, 16'h0010, 1);
        run_window(16'h0240, 16'h0020, 2);
        run_window(16'h0100, 16'h0010, 3);

        run_window(16'h0200, 16'h0020, 4);
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_valid", 128'(row_valid), 128'(0));
        check_eq("post_rst_busy", 128'(busy), 128'(0));
        run_window(16'h0300, 16'h0008, 0);

        run_window(16'hFFF8, 16'h0004, 0);
        check_eq("wrap_row1", 128'(got_rows[1]), {8'h0, 56'hFFFD, 64'hFFFC});
        check_eq("wrap_row2", 128'(got_rows[2]), {8'h0, 56'h0001, 64'h0000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
